colour_bar_scene: RTL and testbench

Parametrised colour-bar scene generator for the VGA pipeline. It sits between the VGA timing generator (pixel_x, pixel_y, video_on) and the DAC pins. It draws repeating bars from a palette of up to 8 colours, in vertical or horizontal orientation, with optional per-frame scrolling in either direction. Bar position is tracked with counters only; there is no divide or modulo hardware.

---
 rtl/colour_bar_scene.sv | 133 +++++++++++++
 tb/tb_colour_bar_scene.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/colour_bar_scene.sv
// Colour-bar scene generator: repeating palette bars, vertical or horizontal,
// with per-frame scrolling. Bar position is tracked by counters, no dividers.
module colour_bar_scene #(
  parameter int unsigned H_VIDEO       = 640,
  parameter int unsigned V_VIDEO       = 480,
  parameter int unsigned BAR_WIDTH     = 20,
  parameter int unsigned NUM_COLOURS   = 3,
  parameter logic [23:0] PALETTE       = 24'h15EE54,
  parameter int unsigned COLOUR_BITS   = 1,
  parameter int unsigned SCROLL_PERIOD = 1
) (
  input  logic                   clk_0,
  input  logic                   rst,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   video_on,
  input  logic                   mode,
  input  logic                   scroll_en,
  input  logic                   scroll_dir,
  output logic [COLOUR_BITS-1:0] red,
  output logic [COLOUR_BITS-1:0] green,
  output logic [COLOUR_BITS-1:0] blue
);

  localparam logic [9:0] X_LAST  = 10'(H_VIDEO - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_VIDEO - 1);
  localparam logic [7:0] BW_LAST = 8'(BAR_WIDTH - 1);
  localparam logic [2:0] NC_LAST = 3'(NUM_COLOURS - 1);
  localparam logic [7:0] SP_LAST = 8'(SCROLL_PERIOD - 1);

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] pos;
  } bar_t;

  function automatic bar_t bar_inc(input bar_t b);
    bar_t r;
    r = b;
    if (b.pos == BW_LAST) begin
      r.pos = '0;
      r.idx = (b.idx == NC_LAST) ? 3'd0 : b.idx + 3'd1;
    end else begin
      r.pos = b.pos + 8'd1;
    end
    return r;
  endfunction

  function automatic bar_t bar_dec(input bar_t b);
    bar_t r;
    r = b;
    if (b.pos == '0) begin
      r.pos = BW_LAST;
      r.idx = (b.idx == '0) ? NC_LAST : b.idx - 3'd1;
    end else begin
      r.pos = b.pos - 8'd1;
    end
    return r;
  endfunction

  bar_t       off_q, col_q, line_q;
  bar_t       col_cur, line_cur;
  logic       col_valid, line_valid;
  logic       mode_q, scroll_q, dir_q;
  logic [7:0] div_q;
  logic       fb, line_start, col_ok, line_ok, pix_ok;
  logic [2:0] sel, rgb;

  always_comb begin
    fb         = video_on && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
    line_start = video_on && (pixel_x == '0);
    // Counter registers hold the next pixel's/line's position; at a line
    // start the current value comes from the offset (or the stepped line).
    col_cur    = line_start ? off_q : col_q;
    line_cur   = line_q;
    if (line_start)
      line_cur = (pixel_y == '0) ? off_q : bar_inc(line_q);
    col_ok  = line_start || col_valid;
    line_ok = (line_start && (pixel_y == '0)) || line_valid;
    sel     = mode_q ? line_cur.idx : col_cur.idx;
    pix_ok  = mode_q ? line_ok : col_ok;
    rgb     = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (sel == 3'(k)) rgb = PALETTE[3*k +: 3];
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      off_q      <= '0;
      col_q      <= '0;
      line_q     <= '0;
      col_valid  <= 1'b0;
      line_valid <= 1'b0;
      mode_q     <= 1'b0;
      scroll_q   <= 1'b0;
      dir_q      <= 1'b0;
      div_q      <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      if (video_on)
        col_q <= bar_inc(col_cur);
      if (line_start) begin
        col_valid <= 1'b1;
        line_q    <= line_cur;
        if (pixel_y == '0) line_valid <= 1'b1;
      end
      if (fb) begin
        mode_q   <= mode;
        scroll_q <= scroll_en;
        dir_q    <= scroll_dir;
        if (scroll_q) begin
          if (div_q == SP_LAST) begin
            div_q <= '0;
            off_q <= dir_q ? bar_dec(off_q) : bar_inc(off_q);
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
      end
      if (video_on && pix_ok) begin
        red   <= {COLOUR_BITS{rgb[2]}};
        green <= {COLOUR_BITS{rgb[1]}};
        blue  <= {COLOUR_BITS{rgb[0]}};
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_colour_bar_scene.sv
// Directed bench for colour_bar_scene: default config plus an 8-colour,
// 4-bit, 10-pixel-bar instance sharing the same pixel stream.
module tb_colour_bar_scene;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, mode, scroll_en, scroll_dir;
  logic       red, green, blue;
  logic [3:0] red2, green2, blue2;

  int n_total = 0;
  int n_bad   = 0;

  always #20 clk_0 = ~clk_0;

  colour_bar_scene dut (
    .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .mode(mode), .scroll_en(scroll_en),
    .scroll_dir(scroll_dir), .red(red), .green(green), .blue(blue)
  );

  colour_bar_scene #(.BAR_WIDTH(10), .NUM_COLOURS(8), .COLOUR_BITS(4)) dut8 (
    .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .mode(mode), .scroll_en(scroll_en),
    .scroll_dir(scroll_dir), .red(red2), .green(green2), .blue(blue2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one pixel and return just after the edge that registers it.
  task automatic pix(input int x, input int y, input logic von);
    @(negedge clk_0);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    @(posedge clk_0);
    #1;
  endtask

  task automatic frame_end();
    pix(639, 479, 1'b1);
  endtask

  function automatic logic [31:0] rgb1();
    return {29'd0, red, green, blue};
  endfunction

  function automatic logic [31:0] rgb4();
    return {20'd0, red2, green2, blue2};
  endfunction

  initial begin
    rst = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    mode = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
    repeat (2) @(posedge clk_0);
    #1;
    check("reset rgb", rgb1(), 32'h0);
    check("reset rgb8", rgb4(), 32'h0);
    @(negedge clk_0) rst = 1'b1;

    // Vertical bars, offset 0
    for (int x = 0; x < 640; x++) begin
      pix(x, 0, 1'b1);
      case (x)
        0, 19, 60: check($sformatf("vert x=%0d", x), rgb1(), 32'h4);
        20, 39, 639: check($sformatf("vert x=%0d", x), rgb1(), 32'h2);
        40, 59:    check($sformatf("vert x=%0d", x), rgb1(), 32'h1);
        default: ;
      endcase
      case (x)
        29:     check($sformatf("pal8 x=%0d", x), rgb4(), 32'h00F);
        30, 39: check($sformatf("pal8 x=%0d", x), rgb4(), 32'hFFF);
        70, 79: check($sformatf("pal8 x=%0d", x), rgb4(), 32'h000);
        80:     check($sformatf("pal8 x=%0d", x), rgb4(), 32'hF00);
        default: ;
      endcase
    end

    pix(10, 0, 1'b0);
    check("video_off", rgb1(), 32'h0);
    check("video_off8", rgb4(), 32'h0);

    // Horizontal bars
    mode = 1'b1;
    frame_end();
    for (int y = 0; y < 480; y++) begin
      pix(0, y, 1'b1);
      if (y == 0)   check("horiz y=0", rgb1(), 32'h4);
      if (y == 25)  check("horiz y=25 x=0", rgb1(), 32'h2);
      if (y == 479) check("horiz y=479", rgb1(), 32'h1);
      pix(5, y, 1'b1);
      if (y == 25)  check("horiz y=25 x=5", rgb1(), 32'h2);
    end

    // Mode change mid-frame takes effect only after the next frame boundary
    mode = 1'b0;
    for (int y = 0; y <= 200; y++) begin
      pix(0, y, 1'b1);
      pix(5, y, 1'b1);
    end
    check("mode hold y=200", rgb1(), 32'h2);
    frame_end();
    for (int x = 0; x <= 20; x++) begin
      pix(x, 0, 1'b1);
      if (x == 19) check("mode new x=19", rgb1(), 32'h4);
      if (x == 20) check("mode new x=20", rgb1(), 32'h2);
    end

    // Forward scroll: first boundary only latches scroll_en, then 5 steps
    scroll_en = 1'b1; scroll_dir = 1'b0;
    frame_end();
    repeat (5) frame_end();
    for (int x = 0; x <= 300; x++) begin
      pix(x, 0, 1'b1);
      case (x)
        0, 14, 300: check($sformatf("fwd x=%0d", x), rgb1(), 32'h4);
        15, 34:     check($sformatf("fwd x=%0d", x), rgb1(), 32'h2);
        35:         check($sformatf("fwd x=%0d", x), rgb1(), 32'h1);
        default: ;
      endcase
    end

    // Asynchronous reset mid-line
    scroll_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst async", rgb1(), 32'h0);
    check("rst async8", rgb4(), 32'h0);
    @(negedge clk_0) rst = 1'b1;
    pix(301, 0, 1'b1);
    check("post-rst black", rgb1(), 32'h0);
    for (int x = 0; x <= 20; x++) begin
      pix(x, 0, 1'b1);
      if (x == 0)  check("rst off x=0", rgb1(), 32'h4);
      if (x == 19) check("rst off x=19", rgb1(), 32'h4);
      if (x == 20) check("rst off x=20", rgb1(), 32'h2);
    end

    // Backward scroll by one step
    scroll_en = 1'b1; scroll_dir = 1'b1;
    frame_end();
    frame_end();
    for (int x = 0; x <= 21; x++) begin
      pix(x, 0, 1'b1);
      case (x)
        0:     check($sformatf("bwd x=%0d", x), rgb1(), 32'h1);
        1, 20: check($sformatf("bwd x=%0d", x), rgb1(), 32'h4);
        21:    check($sformatf("bwd x=%0d", x), rgb1(), 32'h2);
        default: ;
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
